// File: rtl/bopit_game_core.sv
// rtl/bopit_game_core.sv - tick-paced reaction game core: random commands, edge/toggle actions, scaled deadline.
// Optional high-score tracking is enabled with `define BOPIT_HISCORE_EN.
module bopit_game_core #(
  parameter int              N_CMD     = 3,
  parameter int              SCORE_W   = 7,
  parameter int              T_START   = 3,
  parameter int              T_MIN     = 1,
  parameter int              SPEEDUP   = 10,
  parameter int              LOSS_HOLD = 3,
  parameter logic [N_CMD-1:0] EDGE_MASK = 3'b010,
  parameter logic [7:0]      LFSR_SEED = 8'hA5,
  localparam int             TL_W      = $clog2(T_START+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic [N_CMD-1:0]   act_in,
  output logic [N_CMD-1:0]   cmd_onehot,
  output logic [2:0]         cmd_idx,
  output logic [TL_W-1:0]    time_left,
  output logic [SCORE_W-1:0] score,
  output logic               loss,
  output logic               busy
`ifdef BOPIT_HISCORE_EN
  ,
  output logic [SCORE_W-1:0] hiscore,
  output logic               new_record
`endif
);

  localparam int LC_W = $clog2(LOSS_HOLD+1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_LOSS  = 2'd3;

  logic [1:0]         r_state;
  logic [7:0]         r_lfsr;
  logic [N_CMD-1:0]   r_act_prev;
  logic               r_prime;
  logic [2:0]         r_cmd_idx;
  logic [TL_W-1:0]    r_time_left;
  logic [SCORE_W-1:0] r_score;
  logic [LC_W-1:0]    r_loss_cnt;

  logic [N_CMD-1:0]   w_ev;
  logic [N_CMD-1:0]   w_sel;
  logic               w_hit;
  logic               w_wrong;
  logic               w_timeout;
  logic               w_enter_loss;
  logic               w_leave_loss;
  logic [31:0]        w_lvl;
  logic [TL_W-1:0]    w_deadline;
  logic [7:0]         w_lfsr_next;
  logic [2:0]         w_cmd_next;
  logic [SCORE_W-1:0] w_score_inc;

  // Levels already present when reset releases must not count as actions.
  assign w_ev = r_prime ? '0 :
                ((EDGE_MASK & (act_in ^ r_act_prev)) | (~EDGE_MASK & act_in & ~r_act_prev));

  assign w_sel     = N_CMD'(1) << r_cmd_idx;
  assign w_hit     = |(w_ev & w_sel);
  assign w_wrong   = |(w_ev & ~w_sel);
  assign w_timeout = tick && (r_time_left == TL_W'(1));

  // Priority inside WAIT: wrong channel, then correct channel, then timeout.
  assign w_enter_loss = (r_state == S_WAIT) && (w_wrong || (!w_hit && w_timeout));
  assign w_leave_loss = (r_state == S_LOSS) && tick && (r_loss_cnt == LC_W'(1));

  assign w_lfsr_next = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
  assign w_cmd_next  = 3'(r_lfsr % 8'(N_CMD));
  assign w_score_inc = (&r_score) ? r_score : r_score + 1'b1;

  assign w_lvl      = 32'(r_score) / 32'(SPEEDUP);
  assign w_deadline = (w_lvl + 32'(T_MIN) >= 32'(T_START)) ? TL_W'(T_MIN)
                                                            : TL_W'(32'(T_START) - w_lvl);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_lfsr      <= LFSR_SEED;
      r_act_prev  <= '0;
      r_prime     <= 1'b1;
      r_cmd_idx   <= '0;
      r_time_left <= '0;
      r_score     <= '0;
      r_loss_cnt  <= '0;
    end else begin
      r_lfsr     <= w_lfsr_next;
      r_act_prev <= act_in;
      r_prime    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_score <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cmd_idx   <= w_cmd_next;
          r_time_left <= w_deadline;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (w_enter_loss) begin
            r_loss_cnt <= LC_W'(LOSS_HOLD);
            r_state    <= S_LOSS;
          end else if (w_hit) begin
            r_score <= w_score_inc;
            r_state <= S_ISSUE;
          end else if (tick) begin
            r_time_left <= r_time_left - 1'b1;
          end
        end
        S_LOSS: begin
          if (w_leave_loss) begin
            r_state <= S_IDLE;
          end else if (tick) begin
            r_loss_cnt <= r_loss_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef BOPIT_HISCORE_EN
  logic [SCORE_W-1:0] r_hiscore;
  logic               r_new_record;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hiscore    <= '0;
      r_new_record <= 1'b0;
    end else if (w_enter_loss) begin
      if (r_score > r_hiscore) begin
        r_hiscore    <= r_score;
        r_new_record <= 1'b1;
      end else begin
        r_new_record <= 1'b0;
      end
    end else if (w_leave_loss) begin
      r_new_record <= 1'b0;
    end
  end

  assign hiscore    = r_hiscore;
  assign new_record = r_new_record;
`endif

  assign cmd_onehot = (r_state == S_WAIT) ? w_sel : '0;
  assign cmd_idx    = r_cmd_idx;
  assign time_left  = r_time_left;
  assign score      = r_score;
  assign loss       = (r_state == S_LOSS);
  assign busy       = (r_state == S_ISSUE) || (r_state == S_WAIT);

endmodule

// File: tb/tb_bopit_game_core.sv
// tb/tb_bopit_game_core.sv - scoreboard bench for bopit_game_core with a game-rule reference model.
// Define BOPIT_HISCORE_EN to also check hiscore/new_record.
module tb_bopit_game_core;

  localparam int         N  = 3;
  localparam logic [2:0] EM = 3'b010;
  localparam int         SW = 7;
  localparam int         TS = 3;
  localparam int         TM = 1;
  localparam int         SP = 10;
  localparam int         LH = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [2:0] act_in = 3'b010;
  logic [2:0] cmd_onehot;
  logic [2:0] cmd_idx;
  logic [1:0] time_left;
  logic [6:0] score;
  logic       loss;
  logic       busy;
  logic [6:0] hiscore;
  logic       new_record;

  always #5 clk = ~clk;

  bopit_game_core dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .act_in     (act_in),
    .cmd_onehot (cmd_onehot),
    .cmd_idx    (cmd_idx),
    .time_left  (time_left),
    .score      (score),
    .loss       (loss),
    .busy       (busy)
`ifdef BOPIT_HISCORE_EN
    ,
    .hiscore    (hiscore),
    .new_record (new_record)
`endif
  );

`ifndef BOPIT_HISCORE_EN
  assign hiscore    = '0;
  assign new_record = 1'b0;
`endif

  typedef enum int {M_IDLE, M_ISSUE, M_WAIT, M_LOSS} mstate_t;

  typedef struct {
    int         score;
    int         tl;
    int         idx;
    logic [2:0] oh;
    logic       loss;
    logic       busy;
    int         hs;
    logic       nr;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  mstate_t    m_state;
  logic [7:0] m_lfsr;
  logic [2:0] m_prev;
  bit         m_prime;
  int         m_score, m_tl, m_cmd, m_lcnt, m_hs;
  bit         m_nr;
  logic [2:0] cur_act = 3'b010;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_lfsr  = 8'hA5;
    m_prev  = 3'b000;
    m_prime = 1'b1;
    m_score = 0;
    m_tl    = 0;
    m_cmd   = 0;
    m_lcnt  = 0;
    m_hs    = 0;
    m_nr    = 1'b0;
  endtask

  task automatic enter_loss();
    m_state = M_LOSS;
    m_lcnt  = LH;
    if (m_score > m_hs) begin
      m_hs = m_score;
      m_nr = 1'b1;
    end else begin
      m_nr = 1'b0;
    end
  endtask

  task automatic model_step(input bit tk, input bit st, input logic [2:0] a);
    logic [2:0] ev;
    logic [2:0] want;
    int d;
    ev   = m_prime ? 3'b000 : ((EM & (a ^ m_prev)) | (~EM & a & ~m_prev));
    want = 3'(1 << m_cmd);
    case (m_state)
      M_IDLE: if (st) begin m_score = 0; m_state = M_ISSUE; end
      M_ISSUE: begin
        m_cmd   = int'(m_lfsr) % N;
        d       = TS - m_score / SP;
        m_tl    = (d < TM) ? TM : d;
        m_state = M_WAIT;
      end
      M_WAIT: begin
        if ((ev & ~want) != 0) enter_loss();
        else if ((ev & want) != 0) begin
          if (m_score < (1 << SW) - 1) m_score++;
          m_state = M_ISSUE;
        end else if (tk) begin
          if (m_tl == 1) enter_loss();
          else m_tl--;
        end
      end
      M_LOSS: if (tk) begin
        m_lcnt--;
        if (m_lcnt == 0) begin m_state = M_IDLE; m_nr = 1'b0; end
      end
      default: ;
    endcase
    m_lfsr  = {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
    m_prev  = a;
    m_prime = 1'b0;
  endtask

  // Drive one cycle from a negedge, predict the state after the next posedge.
  task automatic cyc(input bit tk, input bit st, input logic [2:0] a);
    exp_t e;
    tick   = tk;
    start  = st;
    act_in = a;
    cur_act = a;
    model_step(tk, st, a);
    e.score = m_score;
    e.tl    = m_tl;
    e.idx   = m_cmd;
    e.oh    = (m_state == M_WAIT) ? 3'(1 << m_cmd) : 3'b000;
    e.loss  = (m_state == M_LOSS);
    e.busy  = (m_state == M_ISSUE) || (m_state == M_WAIT);
    e.hs    = m_hs;
    e.nr    = m_nr;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic go_wait();
    for (int n = 0; n < 10 && m_state != M_WAIT; n++) cyc(1'b0, 1'b0, cur_act);
  endtask

  // Produce an event on every channel in mask; held-high buttons are released first.
  task automatic fire(input logic [2:0] mask, input bit tk);
    logic [2:0] lo;
    lo = cur_act & ~(mask & ~EM);
    if (lo != cur_act) cyc(1'b0, 1'b0, lo);
    cyc(tk, 1'b0, (cur_act ^ (mask & EM)) | (mask & ~EM));
  endtask

  task automatic fire_correct(input bit tk);
    go_wait();
    fire(3'(1 << m_cmd), tk);
  endtask

  task automatic drain_loss();
    for (int n = 0; n < 60 && m_state == M_LOSS; n++)
      cyc(1'($urandom % 2), 1'($urandom % 2), cur_act ^ 3'($urandom));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("score",      32'(score),      32'(e.score));
        check("time_left",  32'(time_left),  32'(e.tl));
        check("cmd_idx",    32'(cmd_idx),    32'(e.idx));
        check("cmd_onehot", 32'(cmd_onehot), 32'(e.oh));
        check("loss",       32'(loss),       32'(e.loss));
        check("busy",       32'(busy),       32'(e.busy));
`ifdef BOPIT_HISCORE_EN
        check("hiscore",    32'(hiscore),    32'(e.hs));
        check("new_record", 32'(new_record), 32'(e.nr));
`endif
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_score",  32'(score),      0);
    check("rst_tl",     32'(time_left),  0);
    check("rst_idx",    32'(cmd_idx),    0);
    check("rst_onehot", 32'(cmd_onehot), 0);
    check("rst_loss",   32'(loss),       0);
    check("rst_busy",   32'(busy),       0);
`ifdef BOPIT_HISCORE_EN
    check("rst_hiscore", 32'(hiscore),   0);
    check("rst_newrec",  32'(new_record), 0);
`endif
  endtask

  initial begin : driver
    logic [2:0] a;
    int r;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;

    // Level held through reset, then start: reaches WAIT with score 0, deadline 3.
    cyc(1'b0, 1'b0, 3'b010);
    cyc(1'b0, 1'b0, 3'b010);
    cyc(1'b0, 1'b1, 3'b010);
    go_wait();

    // Score 5, then correct+wrong together loses with score unchanged.
    repeat (5) fire_correct(1'b0);
    go_wait();
    fire(3'(1 << m_cmd) | 3'(1 << ((m_cmd + 1) % N)), 1'b0);
    drain_loss();
    repeat (2) cyc(1'b0, 1'b0, cur_act);

    // Score 2, then three ticks time out; three more ticks return to IDLE.
    cyc(1'b0, 1'b1, cur_act);
    repeat (2) fire_correct(1'b0);
    go_wait();
    repeat (6) cyc(1'b1, 1'b0, cur_act);
    repeat (2) cyc(1'b0, 1'b0, cur_act);

    // Long game past saturation, ticks and ignored starts mixed in.
    cyc(1'b0, 1'b1, cur_act);
    for (int i = 0; i < 135; i++) begin
      go_wait();
      repeat ($urandom_range(0, 2))
        cyc(1'((m_tl > 1) && ($urandom % 2)), 1'($urandom % 4 == 0), cur_act);
      fire_correct(1'($urandom % 2));
    end
    go_wait();
    for (int n = 0; n < 10 && m_state == M_WAIT; n++) cyc(1'b1, 1'b0, cur_act);
    drain_loss();
    repeat (3) cyc(1'b0, 1'b0, cur_act);

    // Free-running random play.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom % 8;
      if (r == 0) a = cur_act ^ 3'($urandom);
      else if (r < 4 && m_state == M_WAIT) a = cur_act ^ 3'(1 << m_cmd);
      else a = cur_act;
      cyc(1'($urandom % 6 == 0), 1'($urandom % 12 == 0), a);
    end
    for (int n = 0; n < 20 && m_state != M_IDLE; n++) cyc(1'b1, 1'b0, cur_act);

    // Reset in the middle of a game.
    cyc(1'b0, 1'b1, cur_act);
    repeat (3) fire_correct(1'b0);
    go_wait();
    rst = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b0, cur_act);
    cyc(1'b0, 1'b1, cur_act);
    repeat (4) fire_correct(1'b0);
    go_wait();
    repeat (3) cyc(1'b0, 1'b0, cur_act);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "timeout");
  end

endmodule
